// File: rtl/config_pkg.sv
// Shared opcodes and FSM state encoding
// for the sequential UART ALU.
package config_pkg;

  localparam logic [7:0] OP_ECHO = 8'hEC;
  localparam logic [7:0] OP_ADD  = 8'hAD;
  localparam logic [7:0] OP_SUB  = 8'h5B;
  localparam logic [7:0] OP_MUL  = 8'hAC;
  localparam logic [7:0] OP_DIV  = 8'hD1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } alu_state_e;

endpackage

// File: rtl/alu_seq_if.sv
// Start/ack handshake bundle between the
// command parser, the ALU and the serialiser.
interface alu_seq_if #(
  parameter int WIDTH_P = 32
);

  logic [7:0]           opcode_i;
  logic [WIDTH_P-1:0]   op1_i;
  logic [WIDTH_P-1:0]   op2_i;
  logic                 start_i;
  logic                 ready_o;
  logic                 busy_o;
  logic [2*WIDTH_P-1:0] result_o;
  logic                 valid_o;
  logic                 err_o;
  logic                 ack_i;

  modport slave (
    input  opcode_i, op1_i, op2_i,
    input  start_i, ack_i,
    output ready_o, busy_o,
    output result_o, valid_o, err_o
  );

  modport master (
    output opcode_i, op1_i, op2_i,
    output start_i, ack_i,
    input  ready_o, busy_o,
    input  result_o, valid_o, err_o
  );

endinterface

// File: rtl/alu_seq_muldiv.sv
// Iterative shift-add multiplier and restoring
// divider sharing one counter and accumulator.
module alu_seq_muldiv #(
  parameter int WIDTH_P = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load_i,
  input  logic                 is_div_i,
  input  logic [WIDTH_P-1:0]   a_i,
  input  logic [WIDTH_P-1:0]   b_i,
  output logic                 done_o,
  output logic [2*WIDTH_P-1:0] result_o
);

  import config_pkg::*;

  localparam int W  = WIDTH_P;
  localparam int CW = $clog2(WIDTH_P + 1);

  logic [CW-1:0]  cnt;
  logic           run;
  logic           div_q;
  logic [W-1:0]   b_q;
  logic [2*W-1:0] acc;

  // mul: acc = {partial, multiplier}
  logic [W:0]     mul_sum;
  logic [2*W-1:0] mul_nxt;

  // div: acc = {remainder, dividend/quotient}
  logic [W:0]     rem_sh;
  logic [W:0]     div_diff;
  logic [2*W-1:0] div_nxt;

  assign mul_sum = {1'b0, acc[2*W-1:W]}
                 + (acc[0] ? {1'b0, b_q}
                           : {(W+1){1'b0}});
  assign mul_nxt = {mul_sum, acc[W-1:1]};

  assign rem_sh   = acc[2*W-1:W-1];
  assign div_diff = rem_sh - {1'b0, b_q};
  assign div_nxt  = div_diff[W]
    ? {rem_sh[W-1:0], acc[W-2:0], 1'b0}
    : {div_diff[W-1:0], acc[W-2:0], 1'b1};

  // high during the last iteration cycle
  assign done_o   = run & (cnt == CW'(W - 1));
  assign result_o = acc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      run   <= 1'b0;
      div_q <= 1'b0;
      b_q   <= '0;
      acc   <= '0;
    end else if (load_i) begin
      cnt   <= '0;
      run   <= 1'b1;
      div_q <= is_div_i;
      b_q   <= b_i;
      acc   <= {{W{1'b0}}, a_i};
    end else if (run) begin
      cnt <= cnt + 1'b1;
      acc <= div_q ? div_nxt : mul_nxt;
      if (done_o) begin
        run <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Multi-cycle UART ALU: FSM, handshake and
// single-cycle ops; mul/div via alu_seq_muldiv.
module alu_seq #(
  parameter int WIDTH_P = 32
) (
  input logic    clk,
  input logic    rst_n,
  alu_seq_if.slave bus
);

  import config_pkg::*;

  localparam int W = WIDTH_P;

  alu_state_e     state;
  logic [2*W-1:0] res_q;
  logic           err_q;
  logic           use_md;

  logic           accept;
  logic           is_echo;
  logic           is_add;
  logic           is_sub;
  logic           is_mul;
  logic           is_div;
  logic           div_zero;
  logic           md_load;
  logic           md_done;
  logic [2*W-1:0] md_res;
  logic [W:0]     sum;
  logic [W:0]     diff;

  assign accept   = bus.start_i & (state == IDLE);
  assign is_echo  = bus.opcode_i == OP_ECHO;
  assign is_add   = bus.opcode_i == OP_ADD;
  assign is_sub   = bus.opcode_i == OP_SUB;
  assign is_mul   = bus.opcode_i == OP_MUL;
  assign is_div   = bus.opcode_i == OP_DIV;
  assign div_zero = bus.op2_i == '0;
  assign md_load  = accept
                  & (is_mul | (is_div & ~div_zero));

  assign sum  = {1'b0, bus.op1_i}
              + {1'b0, bus.op2_i};
  // bit W of the wrapped difference is the borrow
  assign diff = {1'b0, bus.op1_i}
              - {1'b0, bus.op2_i};

  alu_seq_muldiv #(
    .WIDTH_P (W)
  ) u_muldiv (
    .clk      (clk),
    .rst_n    (rst_n),
    .load_i   (md_load),
    .is_div_i (is_div),
    .a_i      (bus.op1_i),
    .b_i      (bus.op2_i),
    .done_o   (md_done),
    .result_o (md_res)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      res_q  <= '0;
      err_q  <= 1'b0;
      use_md <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            res_q  <= '0;
            err_q  <= 1'b0;
            use_md <= 1'b0;
            state  <= DONE;
            unique case (1'b1)
              is_echo: begin
                res_q <= {{W{1'b0}}, bus.op1_i};
              end
              is_add: begin
                res_q <= {{(W-1){1'b0}}, sum};
              end
              is_sub: begin
                res_q <= {{(W-1){1'b0}}, diff};
              end
              is_mul: begin
                use_md <= 1'b1;
                state  <= RUN;
              end
              is_div & ~div_zero: begin
                use_md <= 1'b1;
                state  <= RUN;
              end
              is_div & div_zero: begin
                res_q <= {bus.op1_i, {W{1'b1}}};
                err_q <= 1'b1;
              end
              default: begin
                err_q <= 1'b1;
              end
            endcase
          end
        end
        RUN: begin
          if (md_done) begin
            state <= DONE;
          end
        end
        DONE: begin
          if (bus.ack_i) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.ready_o  = state == IDLE;
  assign bus.busy_o   = state != IDLE;
  assign bus.valid_o  = state == DONE;
  assign bus.err_o    = err_q;
  assign bus.result_o = use_md ? md_res : res_q;

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: directed
// vectors, decoupled driver and monitor.
module tb_alu_seq;

  import config_pkg::*;

  localparam int W = 32;

  typedef struct {
    logic [2*W-1:0] res;
    logic           err;
    int             cyc;
  } exp_t;

  logic clk;
  logic rst_n;
  int   cyc;
  int   checks;
  int   failures;
  exp_t sb[$];

  alu_seq_if #(.WIDTH_P(W)) bus ();

  alu_seq #(
    .WIDTH_P (W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name,
                     input logic [2*W-1:0] got,
                     input logic [2*W-1:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got %h expected %h",
               name, got, want);
    end
  endtask

  // monitor: pop on each new result, then
  // keep checking it for stability while held
  bit   have;
  exp_t cur;
  initial have = 0;
  always @(negedge clk) begin
    if (bus.valid_o === 1'b1) begin
      if (!have) begin
        have = 1;
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_valid: got %h",
                   bus.result_o);
          cur.res = 'x;
          cur.err = 1'bx;
        end else begin
          cur = sb.pop_front();
          chk("latency", 64'(cyc), 64'(cur.cyc));
        end
      end
      if (cur.err !== 1'bx) begin
        chk("result", bus.result_o, cur.res);
        chk("err", 64'(bus.err_o), 64'(cur.err));
      end
    end else begin
      have = 0;
    end
  end

  task automatic run_op(input logic [7:0] opc,
                        input logic [W-1:0] a,
                        input logic [W-1:0] b,
                        input logic [2*W-1:0] res,
                        input logic err,
                        input int lat,
                        input int hold,
                        input bit poke);
    exp_t e;
    bit ok;
    ok = 0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      ok = bus.ready_o;
    end
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL ready_wait: got 0 expected 1");
      return;
    end
    e.res = res;
    e.err = err;
    e.cyc = cyc + lat;
    sb.push_back(e);
    bus.opcode_i = opc;
    bus.op1_i    = a;
    bus.op2_i    = b;
    bus.start_i  = 1'b1;
    @(negedge clk);
    bus.start_i = poke;
    if (poke) begin
      bus.opcode_i = OP_ADD;
      bus.op1_i    = 32'd1;
      bus.op2_i    = 32'd2;
    end else begin
      bus.opcode_i = OP_ECHO;
      bus.op1_i    = ~a;
      bus.op2_i    = ~b;
    end
    ok = 0;
    for (int i = 0; i < lat + 5 && !ok; i++) begin
      ok = bus.valid_o;
      if (!ok) @(negedge clk);
    end
    bus.start_i = 1'b0;
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL valid_wait: got 0 expected 1");
      void'(sb.pop_back());
      return;
    end
    repeat (hold) @(negedge clk);
    chk("busy_held", 64'(bus.busy_o), 64'd1);
    bus.ack_i = 1'b1;
    @(negedge clk);
    bus.ack_i = 1'b0;
    chk("ack_ready", 64'(bus.ready_o), 64'd1);
    chk("ack_valid", 64'(bus.valid_o), 64'd0);
  endtask

  initial begin
    checks       = 0;
    failures     = 0;
    rst_n        = 1'b0;
    bus.opcode_i = '0;
    bus.op1_i    = '0;
    bus.op2_i    = '0;
    bus.start_i  = 1'b0;
    bus.ack_i    = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ready", 64'(bus.ready_o), 64'd1);
    chk("rst_busy", 64'(bus.busy_o), 64'd0);
    chk("rst_valid", 64'(bus.valid_o), 64'd0);
    chk("rst_err", 64'(bus.err_o), 64'd0);
    chk("rst_result", bus.result_o, 64'd0);
    rst_n = 1'b1;

    run_op(OP_ADD, 32'hFFFF_FFFF, 32'd1,
           64'h1_0000_0000, 1'b0, 1, 0, 0);
    run_op(OP_SUB, 32'd3, 32'd5,
           64'h0000_0001_FFFF_FFFE, 1'b0, 1, 0, 0);
    run_op(OP_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
           64'hFFFF_FFFE_0000_0001, 1'b0, 33, 5, 0);
    run_op(OP_DIV, 32'd100, 32'd7,
           64'h0000_0002_0000_000E, 1'b0, 33, 0, 0);
    run_op(OP_DIV, 32'd9, 32'd0,
           64'h0000_0009_FFFF_FFFF, 1'b1, 1, 0, 0);
    run_op(OP_MUL, 32'd12345, 32'd1000,
           64'd12345000, 1'b0, 33, 0, 1);
    run_op(8'h00, 32'h1234, 32'h5678,
           64'd0, 1'b1, 1, 0, 0);
    run_op(OP_ECHO, 32'h0000_1234, 32'hFFFF,
           64'h1234, 1'b0, 1, 2, 0);
    run_op(OP_DIV, 32'hFFFF_FFFF, 32'd3,
           64'h0000_0000_5555_5555, 1'b0, 33, 0, 0);
    run_op(OP_DIV, 32'd5, 32'd9,
           64'h0000_0005_0000_0000, 1'b0, 33, 0, 0);
    run_op(OP_MUL, 32'h0001_0000, 32'h0001_0000,
           64'h1_0000_0000, 1'b0, 33, 0, 0);
    run_op(OP_SUB, 32'd9, 32'd9,
           64'd0, 1'b0, 1, 0, 0);

    // stray ack in IDLE must be ignored
    @(negedge clk);
    bus.ack_i = 1'b1;
    @(negedge clk);
    bus.ack_i = 1'b0;
    chk("stray_ack_ready", 64'(bus.ready_o), 64'd1);
    chk("stray_ack_valid", 64'(bus.valid_o), 64'd0);

    // reset in the middle of a multiply
    bus.opcode_i = OP_MUL;
    bus.op1_i    = 32'hFFFF_FFFF;
    bus.op2_i    = 32'h7;
    bus.start_i  = 1'b1;
    @(negedge clk);
    bus.start_i = 1'b0;
    chk("mul_busy", 64'(bus.busy_o), 64'd1);
    repeat (8) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_ready", 64'(bus.ready_o), 64'd1);
    chk("mid_busy", 64'(bus.busy_o), 64'd0);
    chk("mid_valid", 64'(bus.valid_o), 64'd0);
    chk("mid_err", 64'(bus.err_o), 64'd0);
    chk("mid_result", bus.result_o, 64'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    chk("post_rst_valid", 64'(bus.valid_o), 64'd0);
    run_op(OP_ECHO, 32'hCAFE_F00D, 32'd0,
           64'h0000_0000_CAFE_F00D, 1'b0, 1, 0, 0);

    repeat (3) @(negedge clk);
    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
